// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
//
// Shared 8-bit RAM port between the MEM stage and the memory controller.
// One byte moves per granted cycle; read data returns one cycle after its
// address was presented.
//
// Signals:
//   mem_req_out   stage -> ctrl   port request
//   mem_grant_in  ctrl  -> stage  port granted this cycle
//   ram_addr_out  stage -> ctrl   byte address
//   ram_wr_out    stage -> ctrl   1 = write, 0 = read
//   ram_dout_out  stage -> ctrl   write byte
//   ram_din_in    ctrl  -> stage  read byte (one cycle after address)
//
// Modports: master = MEM stage, slave = memory controller / RAM.
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        mem_req_out;
  logic        mem_grant_in;
  logic [31:0] ram_addr_out;
  logic        ram_wr_out;
  logic [7:0]  ram_dout_out;
  logic [7:0]  ram_din_in;

  modport master (
    output mem_req_out,
    output ram_addr_out,
    output ram_wr_out,
    output ram_dout_out,
    input  mem_grant_in,
    input  ram_din_in
  );

  modport slave (
    input  mem_req_out,
    input  ram_addr_out,
    input  ram_wr_out,
    input  ram_dout_out,
    output mem_grant_in,
    output ram_din_in
  );
endinterface

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage RISC-V core. Non-memory results are passed
// combinationally toward MEM/WB. Loads and stores are broken into
// little-endian byte transfers over the shared 8-bit RAM port; while a
// transfer is in progress stall_req_out holds the EX->MEM register stable,
// so cmdtype/address/data inputs are read live throughout the access.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                global ready; low freezes all state
//   cmdtype_in            instruction type from EX->MEM
//   rsd_addr_in/_data_in  destination register / ALU result
//   write_rsd_in          destination write enable
//   mem_addr_in           effective byte address
//   store_data_in         store source data
//   rsd_addr_out/_data_out, write_rsd_out   to MEM/WB
//   stall_req_out         stall request to stall controller
//   ram_if                RAM port (master side)
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter logic [5:0] CMD_LB  = 6'd10,
  parameter logic [5:0] CMD_LH  = 6'd11,
  parameter logic [5:0] CMD_LW  = 6'd12,
  parameter logic [5:0] CMD_LBU = 6'd13,
  parameter logic [5:0] CMD_LHU = 6'd14,
  parameter logic [5:0] CMD_SB  = 6'd15,
  parameter logic [5:0] CMD_SH  = 6'd16,
  parameter logic [5:0] CMD_SW  = 6'd17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [5:0]            cmdtype_in,
  input  logic [4:0]            rsd_addr_in,
  input  logic [31:0]           rsd_data_in,
  input  logic                  write_rsd_in,
  input  logic [31:0]           mem_addr_in,
  input  logic [31:0]           store_data_in,
  output logic [4:0]            rsd_addr_out,
  output logic [31:0]           rsd_data_out,
  output logic                  write_rsd_out,
  output logic                  stall_req_out,
  mem_access_stage_if.master    ram_if
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    WAIT_LAST = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Byte lane extraction from a 32-bit word.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
    endcase
    return b;
  endfunction

  // Replace one byte lane of a 32-bit word.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    unique case (idx)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      2'd3: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Widen the assembled bytes to 32 bits; len_m1 is access length minus one.
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] len_m1,
                                              input logic sgn);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        r;
    b_s = raw[7:0];
    h_s = raw[15:0];
    unique case (len_m1)
      2'd0:    r = sgn ? 32'(b_s) : {24'd0, raw[7:0]};
      2'd1:    r = sgn ? 32'(h_s) : {16'd0, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------
  logic       is_load, is_store, is_mem, is_sgn;
  logic [1:0] len_m1;

  always_comb begin
    is_load  = (cmdtype_in == CMD_LB) || (cmdtype_in == CMD_LH) || (cmdtype_in == CMD_LW) ||
               (cmdtype_in == CMD_LBU) || (cmdtype_in == CMD_LHU);
    is_store = (cmdtype_in == CMD_SB) || (cmdtype_in == CMD_SH) || (cmdtype_in == CMD_SW);
    is_mem   = is_load || is_store;
    is_sgn   = (cmdtype_in == CMD_LB) || (cmdtype_in == CMD_LH);
    len_m1   = 2'd0;
    if ((cmdtype_in == CMD_LH) || (cmdtype_in == CMD_LHU) || (cmdtype_in == CMD_SH))
      len_m1 = 2'd1;
    if ((cmdtype_in == CMD_LW) || (cmdtype_in == CMD_SW))
      len_m1 = 2'd3;
  end

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] asm_q, asm_d;
  // A load byte was issued last active cycle and its data is on ram_din_in.
  logic        pend_q, pend_d;
  logic [1:0]  pidx_q, pidx_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    asm_d   = asm_q;
    pend_d  = pend_q;
    pidx_d  = pidx_q;
    if (rdy_in) begin
      if (pend_q && ((state_q == ACCESS) || (state_q == WAIT_LAST))) begin
        asm_d  = put_byte(asm_q, pidx_q, ram_if.ram_din_in);
        pend_d = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (is_mem && ram_if.mem_grant_in) begin
            state_d = ACCESS;
            k_d     = 2'd0;
            asm_d   = '0;
            pend_d  = 1'b0;
          end
        end
        ACCESS: begin
          // Only a granted cycle transfers a byte; otherwise address and k hold.
          if (ram_if.mem_grant_in) begin
            pend_d = is_load;
            pidx_d = k_q;
            if (k_q == len_m1)
              state_d = is_load ? WAIT_LAST : DONE;
            else
              k_d = k_q + 2'd1;
          end
        end
        WAIT_LAST: state_d = DONE;
        DONE: begin
          state_d = IDLE;
          k_d     = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      asm_q   <= '0;
      pend_q  <= 1'b0;
      pidx_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      asm_q   <= asm_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: functions of current state and held inputs. During reset the
  // port is forced quiet so an aborted store cannot emit another write.
  // ---------------------------------------------------------------------
  logic        mem_req_c, ram_wr_c;
  logic [31:0] ram_addr_c;
  logic [7:0]  ram_dout_c;

  always_comb begin
    rsd_addr_out  = rsd_addr_in;
    rsd_data_out  = '0;
    write_rsd_out = 1'b0;
    stall_req_out = 1'b0;
    mem_req_c     = 1'b0;
    ram_wr_c      = 1'b0;
    ram_addr_c    = '0;
    ram_dout_c    = '0;
    if (rst_in) begin
      rsd_data_out  = rsd_data_in;
      write_rsd_out = write_rsd_in;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_mem) begin
            stall_req_out = 1'b1;
            mem_req_c     = 1'b1;
          end else begin
            rsd_data_out  = rsd_data_in;
            write_rsd_out = write_rsd_in;
          end
        end
        ACCESS: begin
          stall_req_out = 1'b1;
          mem_req_c     = 1'b1;
          ram_addr_c    = mem_addr_in + {30'd0, k_q};
          if (is_store) begin
            ram_wr_c   = 1'b1;
            ram_dout_c = pick_byte(store_data_in, k_q);
          end
        end
        WAIT_LAST: stall_req_out = 1'b1;
        DONE: begin
          if (is_load) begin
            rsd_data_out  = load_extend(asm_q, len_m1, is_sgn);
            write_rsd_out = write_rsd_in;
          end
        end
      endcase
    end
  end

  assign ram_if.mem_req_out  = mem_req_c;
  assign ram_if.ram_wr_out   = ram_wr_c;
  assign ram_if.ram_addr_out = ram_addr_c;
  assign ram_if.ram_dout_out = ram_dout_c;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the 5-stage RISC-V core: the consumer end of the EX→MEM pipeline register. Non-memory results pass straight through toward MEM/WB. Loads and stores are sequenced as little-endian byte accesses over the shared 8-bit RAM port, arbitrated by the memory controller. While an access is in flight the block asserts a stall request to the stall controller, so the EX→MEM register holds its outputs stable.

## Interface
- CMD_LB, default 6'd10: cmdtype code, load byte, sign-extended
- CMD_LH, default 6'd11: load half, sign-extended
- CMD_LW, default 6'd12: load word
- CMD_LBU, default 6'd13: load byte, zero-extended
- CMD_LHU, default 6'd14: load half, zero-extended
- CMD_SB, default 6'd15: store byte
- CMD_SH, default 6'd16: store half
- CMD_SW, default 6'd17: store word
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low freezes all state
- cmdtype_in  in  6  instruction type from EX→MEM register
- rsd_addr_in  in  5  destination register
- rsd_data_in  in  32  ALU result (non-memory ops)
- write_rsd_in  in  1  destination write enable
- mem_addr_in  in  32  effective byte address
- store_data_in  in  32  store source data
- rsd_addr_out  out  5  to MEM/WB
- rsd_data_out  out  32  to MEM/WB
- write_rsd_out  out  1  to MEM/WB
- stall_req_out  out  1  stall request to stall controller
- mem_req_out  out  1  RAM port request to memory controller
- mem_grant_in  in  1  RAM port granted this cycle
- ram_addr_out  out  32  byte address
- ram_wr_out  out  1  1 = write, 0 = read
- ram_dout_out  out  8  write byte
- ram_din_in  in  8  read byte; valid one cycle after its address

## Operation
- FSM states: IDLE, ACCESS, WAIT_LAST, DONE. Byte counter k is 2 bits. Length n is 1 for B/BU, 2 for H/HU, 4 for W.
- **IDLE, non-memory cmdtype:**
  - rsd_addr_out, rsd_data_out and write_rsd_out are combinational copies of the inputs.
  - stall_req_out = 0; mem_req_out = 0.
- **IDLE, memory cmdtype:**
  - stall_req_out = 1 and mem_req_out = 1; write_rsd_out = 0.
  - If mem_grant_in = 1: go to ACCESS with k = 0. Otherwise stay in IDLE.
- **ACCESS:**
  - Drive mem_req_out = 1, stall_req_out = 1, ram_addr_out = mem_addr_in + k (mod 2^32).
  - Stores: ram_wr_out = 1, ram_dout_out = store_data_in[8k+7:8k].
  - Loads: ram_wr_out = 0. ram_din_in sampled in cycle j is stored as byte j−1.
  - Advance k only in cycles where mem_grant_in = 1. If grant drops, address and k hold.
  - After byte n−1 is issued: stores go to DONE, loads go to WAIT_LAST.
- **WAIT_LAST (loads only):**
  - Capture the final byte; mem_req_out = 0; stall_req_out = 1; go to DONE.
- **DONE, lasts exactly one cycle:**
  - stall_req_out = 0; mem_req_out = 0.
  - Loads: rsd_data_out = assembled value, sign- or zero-extended to 32 bits; write_rsd_out = write_rsd_in; rsd_addr_out = rsd_addr_in.
  - Stores: write_rsd_out = 0.
  - Next state is IDLE unconditionally. The next instruction is on the inputs in that IDLE cycle, so back-to-back identical commands are two separate accesses.
- **Outputs outside DONE and non-memory IDLE:**
  - ram_wr_out = 0 whenever not in ACCESS, so no spurious writes occur.
  - rsd_data_out = 0, write_rsd_out = 0 during IDLE-with-memory-cmd, ACCESS and WAIT_LAST.
- **rdy_in = 0:** state, k and the assembly register hold. Combinational outputs still follow the current state.
- Alignment is not checked. Misaligned accesses are simply byte-sequential.

## Timing
- Reset, applied on the edge: state IDLE, k = 0, assembly register = 0.
  - Registered or state-derived outputs, during reset and until a memory command arrives: stall_req_out = 0, mem_req_out = 0, ram_wr_out = 0, ram_addr_out = 0, ram_dout_out = 0.
  - rsd_* outputs follow the non-memory pass-through rule.
- Reset mid-access aborts immediately: the next cycle is IDLE, and no further ram_wr_out pulse is issued.
- Cycle counts with grant held high (IDLE → DONE inclusive, stall_req_out high in all but DONE):
  - Store: n+2 cycles, so SW = 6, SB = 3.
  - Load: n+3 cycles, so LW = 7, LB = 4.
- Each cycle mem_grant_in is low in IDLE or ACCESS adds exactly one cycle.

## Test plan
- **Non-memory pass-through:** cmd ADD, rsd_addr 5, data 0x1234 → same-cycle outputs 5 / 0x1234 / 1; stall_req_out = 0, mem_req_out = 0.
- **SW:** addr 0x100, data 0xAABBCCDD, grant high → writes DD@0x100, CC@0x101, BB@0x102, AA@0x103 on consecutive cycles; stall high 5 cycles; write_rsd_out = 0 in DONE.
- **LB:** RAM byte 0x80 at 0x20, rsd 7 → DONE cycle 4 shows rsd_data_out 0xFFFFFF80, write 1. Same with LBU → 0x00000080.
- **LH with wrap:** addr 0xFFFFFFFF, bytes 0x34 then 0x12 (at address 0x0) → 0x00001234; ram_addr_out sequence 0xFFFFFFFF, 0x00000000.
- **Grant stall:** LW with grant low 3 cycles in IDLE and 2 cycles mid-ACCESS → DONE at cycle 12; correct word assembled; address holds while grant is low.
- **Disruption:** rdy_in low 2 cycles mid-SH → latency +2, no duplicate writes. Reset asserted during SW byte 2 → no write of byte 3; next cycle IDLE with stall_req_out = 0.
